// File: rtl/rvm_mem_arbiter_if.sv
// rvm_mem_arbiter_if: bus bundle between the two requesters, the arbiter and
// the memory port.
//   m0_* / m1_* : requester handshake (req/addr/wen/wdata in, ack/error out)
//   rdata       : shared read data, valid only with the owning ack
//   mem_*       : single memory port (req/addr/wen/wdata out, rdata/ack/error in)
//   grant       : one-hot owner, 01 = m0, 10 = m1, 00 = idle
// Modports: slave = arbiter view, master = requester/memory-model view.
interface rvm_mem_arbiter_if #(
  parameter int AW = 32
);
  logic          m0_req, m0_ack, m0_error;
  logic [AW-1:0] m0_addr;
  logic [3:0]    m0_wen;
  logic [31:0]   m0_wdata;
  logic          m1_req, m1_ack, m1_error;
  logic [AW-1:0] m1_addr;
  logic [3:0]    m1_wen;
  logic [31:0]   m1_wdata;
  logic [31:0]   rdata;
  logic          mem_req, mem_ack, mem_error;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wen;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [1:0]    grant;

  modport slave (
    input  m0_req, m0_addr, m0_wen, m0_wdata,
    input  m1_req, m1_addr, m1_wen, m1_wdata,
    input  mem_rdata, mem_ack, mem_error,
    output m0_ack, m0_error, m1_ack, m1_error, rdata,
    output mem_req, mem_addr, mem_wen, mem_wdata, grant
  );

  modport master (
    output m0_req, m0_addr, m0_wen, m0_wdata,
    output m1_req, m1_addr, m1_wen, m1_wdata,
    output mem_rdata, mem_ack, mem_error,
    input  m0_ack, m0_error, m1_ack, m1_error, rdata,
    input  mem_req, mem_addr, mem_wen, mem_wdata, grant
  );
endinterface

// File: rtl/rvm_mem_arbiter.sv
// rvm_mem_arbiter: shares one memory port between master 0 (core) and
// master 1 (debug/loader). One transaction at a time, grant held until the
// memory acks or errors, one IDLE bubble between transactions. A watchdog
// aborts a transaction with an error after MAX_WAIT cycles without mem_ack.
// Ports: clk, resetn (async active-low), bus (rvm_mem_arbiter_if.slave).
// Build option: RVM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it m0 has fixed priority.
module rvm_mem_arbiter #(
  parameter int MAX_WAIT = 16,
  parameter int AW       = 32
) (
  input logic              clk,
  input logic              resetn,
  rvm_mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  localparam int          CW   = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] wcnt;
  logic          busy0, busy1, busy, timeout, fail, done, pick1;
  logic [AW-1:0] addr_mux;

  always_comb begin
    busy0   = (state == BUSY0);
    busy1   = (state == BUSY1);
    busy    = busy0 | busy1;
    timeout = busy && (wcnt == WMAX);
    // error (bus or watchdog) takes precedence over a coincident ack
    fail    = busy && (bus.mem_error || timeout);
    done    = busy && bus.mem_ack && !fail;
  end

`ifdef RVM_ARB_ROUND_ROBIN_EN
  logic ptr;  // 0 = m0 preferred, 1 = m1 preferred
  assign pick1 = bus.m1_req && (!bus.m0_req || ptr);

  // pointer moves away only when the preferred master finishes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      ptr <= 1'b0;
    else if ((fail || done) && ((busy0 && !ptr) || (busy1 && ptr)))
      ptr <= ~ptr;
  end
`else
  assign pick1 = bus.m1_req && !bus.m0_req;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.m0_req || bus.m1_req) state_nxt = pick1 ? BUSY1 : BUSY0;
      BUSY0,
      BUSY1:   if (fail || done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      // cleared while idle so every grant starts from zero; saturates at WMAX
      if (!busy)
        wcnt <= '0;
      else if (!bus.mem_ack && wcnt != WMAX)
        wcnt <= wcnt + 1'b1;
    end
  end

  always_comb begin
    addr_mux = busy0 ? bus.m0_addr : busy1 ? bus.m1_addr : '0;
  end

  assign bus.grant     = {busy1, busy0};
  assign bus.mem_req   = busy && !timeout;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wen   = busy0 ? bus.m0_wen   : busy1 ? bus.m1_wen   : 4'h0;
  assign bus.mem_wdata = busy0 ? bus.m0_wdata : busy1 ? bus.m1_wdata : 32'h0;
  assign bus.m0_ack    = busy0 && done;
  assign bus.m1_ack    = busy1 && done;
  assign bus.m0_error  = busy0 && fail;
  assign bus.m1_error  = busy1 && fail;
  assign bus.rdata     = done ? bus.mem_rdata : 32'h0;
endmodule
